// File: rtl/msx_mem_arbiter.sv
// Arbiter sharing the external memory port between the download writer, CPU slots and
// save/load DMA; each access is held for a fixed target latency and acknowledged for one cycle.
module msx_mem_arbiter #(
  parameter int unsigned SDRAM_LAT  = 4,
  parameter int unsigned BRAM_LAT   = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk21m,
  input  logic        reset,
  input  logic        dl_req,
  input  logic [26:0] dl_addr,
  input  logic [7:0]  dl_wdata,
  output logic        dl_ack,
  input  logic        cpu_req,
  input  logic        cpu_sdram,
  input  logic [26:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_wait_n,
  input  logic        sv_req,
  input  logic        sv_sdram,
  input  logic [26:0] sv_addr,
  input  logic        sv_rnw,
  input  logic [7:0]  sv_wdata,
  output logic        sv_ack,
  output logic [7:0]  sv_rdata,
  output logic [26:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_rnw,
  output logic        sdram_ce,
  output logic        bram_ce,
  input  logic [7:0]  ram_dout
);

  if (SDRAM_LAT < 1 || SDRAM_LAT > 15 || BRAM_LAT < 1 || BRAM_LAT > 15 ||
      STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
    $error("msx_mem_arbiter: SDRAM_LAT, BRAM_LAT and STARVE_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {W_DL, W_CPU, W_SV} who_t;

  localparam logic [3:0] SD_CNT     = 4'(SDRAM_LAT - 1);
  localparam logic [3:0] BR_CNT     = 4'(BRAM_LAT - 1);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  who_t        who_q, who_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic [26:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        rnw_q, rnw_d;
  logic        sdce_q, sdce_d;
  logic        brce_q, brce_d;
  logic [7:0]  cpu_rd_q, cpu_rd_d;
  logic [7:0]  sv_rd_q, sv_rd_d;
  logic        sv_first, gnt_cpu, gnt_sv;

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      who_q    <= W_DL;
      cnt_q    <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      rnw_q    <= 1'b1;
      sdce_q   <= 1'b0;
      brce_q   <= 1'b0;
      cpu_rd_q <= '0;
      sv_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      who_q    <= who_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rnw_q    <= rnw_d;
      sdce_q   <= sdce_d;
      brce_q   <= brce_d;
      cpu_rd_q <= cpu_rd_d;
      sv_rd_q  <= sv_rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    who_d    = who_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rnw_d    = rnw_q;
    sdce_d   = sdce_q;
    brce_d   = brce_q;
    cpu_rd_d = cpu_rd_q;
    sv_rd_d  = sv_rd_q;
    gnt_cpu  = 1'b0;
    gnt_sv   = 1'b0;
    // A starved sv overtakes cpu but never dl.
    sv_first = (starve_q == STARVE_TOP) && sv_req;
    case (state_q)
      S_IDLE: begin
        if (dl_req) begin
          who_d   = W_DL;
          addr_d  = dl_addr;
          din_d   = dl_wdata;
          rnw_d   = 1'b0;
          sdce_d  = 1'b1;
          cnt_d   = SD_CNT;
          state_d = S_ACCESS;
        end else if (cpu_req && !sv_first) begin
          gnt_cpu = 1'b1;
          who_d   = W_CPU;
          addr_d  = cpu_addr;
          din_d   = cpu_wdata;
          rnw_d   = cpu_rnw;
          sdce_d  = cpu_sdram;
          brce_d  = !cpu_sdram;
          cnt_d   = cpu_sdram ? SD_CNT : BR_CNT;
          state_d = S_ACCESS;
        end else if (sv_req) begin
          gnt_sv  = 1'b1;
          who_d   = W_SV;
          addr_d  = sv_addr;
          din_d   = sv_wdata;
          rnw_d   = sv_rnw;
          sdce_d  = sv_sdram;
          brce_d  = !sv_sdram;
          cnt_d   = sv_sdram ? SD_CNT : BR_CNT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (rnw_q) begin
            if (who_q == W_CPU) cpu_rd_d = ram_dout;
            else if (who_q == W_SV) sv_rd_d = ram_dout;
          end
          sdce_d  = 1'b0;
          brce_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        rnw_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    starve_d = starve_q;
    if (!sv_req || gnt_sv) starve_d = '0;
    else if (gnt_cpu && starve_q != STARVE_TOP) starve_d = starve_q + 1'b1;
  end

  assign dl_ack     = (state_q == S_DONE) && (who_q == W_DL);
  assign cpu_ack    = (state_q == S_DONE) && (who_q == W_CPU);
  assign sv_ack     = (state_q == S_DONE) && (who_q == W_SV);
  assign cpu_wait_n = !(cpu_req && !cpu_ack);
  assign cpu_rdata  = cpu_rd_q;
  assign sv_rdata   = sv_rd_q;
  assign ram_addr   = addr_q;
  assign ram_din    = din_q;
  assign ram_rnw    = rnw_q;
  assign sdram_ce   = sdce_q;
  assign bram_ce    = brce_q;

endmodule

// File: tb/tb_msx_mem_arbiter.sv
// Directed bench for msx_mem_arbiter: a table of single transactions plus hand-written
// sequences for priority, starvation, reset abort and early request drop.
module tb_msx_mem_arbiter;

  logic        clk21m = 1'b0;
  logic        reset;
  logic        dl_req, cpu_req, sv_req;
  logic [26:0] dl_addr, cpu_addr, sv_addr;
  logic [7:0]  dl_wdata, cpu_wdata, sv_wdata;
  logic        cpu_sdram, cpu_rnw, sv_sdram, sv_rnw;
  logic        dl_ack, cpu_ack, sv_ack, cpu_wait_n;
  logic [7:0]  cpu_rdata, sv_rdata, ram_din, ram_dout;
  logic [26:0] ram_addr;
  logic        ram_rnw, sdram_ce, bram_ce;

  int errors = 0;
  int checks = 0;

  always #5 clk21m = ~clk21m;

  msx_mem_arbiter #(.SDRAM_LAT(4), .BRAM_LAT(2), .STARVE_MAX(8)) dut (
    .clk21m(clk21m), .reset(reset),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_wdata(dl_wdata), .dl_ack(dl_ack),
    .cpu_req(cpu_req), .cpu_sdram(cpu_sdram), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n),
    .sv_req(sv_req), .sv_sdram(sv_sdram), .sv_addr(sv_addr), .sv_rnw(sv_rnw),
    .sv_wdata(sv_wdata), .sv_ack(sv_ack), .sv_rdata(sv_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_rnw(ram_rnw),
    .sdram_ce(sdram_ce), .bram_ce(bram_ce), .ram_dout(ram_dout)
  );

  typedef struct {
    int          who;     // 0 = dl, 1 = cpu, 2 = sv
    bit          sdram;
    logic [26:0] addr;
    bit          rnw;
    logic [7:0]  wdata;
    logic [7:0]  dout;
    int          lat;     // expected ce-high cycles
    logic [7:0]  exp_rd;
  } txn_t;

  txn_t tbl[7];
  logic [7:0] last_cpu_rd = 8'h00;
  logic [7:0] last_sv_rd  = 8'h00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic ack_of(input int who);
    case (who)
      0:       return dl_ack;
      1:       return cpu_ack;
      default: return sv_ack;
    endcase
  endfunction

  task automatic set_req(input int who, input logic v);
    case (who)
      0:       dl_req = v;
      1:       cpu_req = v;
      default: sv_req = v;
    endcase
  endtask

  task automatic run_txn(input int idx, input txn_t t);
    int g, ack_at, ce_cnt;
    bit target_ok, hold_ok, wait_ok;
    @(negedge clk21m);
    ram_dout = t.dout;
    case (t.who)
      0: begin dl_addr = t.addr; dl_wdata = t.wdata; end
      1: begin cpu_addr = t.addr; cpu_wdata = t.wdata; cpu_rnw = t.rnw; cpu_sdram = t.sdram; end
      default: begin sv_addr = t.addr; sv_wdata = t.wdata; sv_rnw = t.rnw; sv_sdram = t.sdram; end
    endcase
    set_req(t.who, 1'b1);
    g = -1; ack_at = -1; ce_cnt = 0;
    target_ok = 1; hold_ok = 1; wait_ok = 1;
    for (int n = 0; n < 40 && ack_at < 0; n++) begin
      @(negedge clk21m);
      if (sdram_ce || bram_ce) begin
        if (g < 0) g = n;
        ce_cnt++;
        if (sdram_ce != t.sdram || bram_ce == t.sdram) target_ok = 0;
        if (ram_addr != t.addr || ram_rnw != t.rnw || (!t.rnw && ram_din != t.wdata)) hold_ok = 0;
      end
      if (ack_of(t.who)) ack_at = n;
      else if (t.who == 1 && cpu_wait_n !== 1'b0) wait_ok = 0;
    end
    chk($sformatf("t%0d_ack_seen", idx), ack_at >= 0, 1);
    chk($sformatf("t%0d_ce_cycles", idx), ce_cnt, t.lat);
    // Ack is visible LAT negedges after the first ce sample, i.e. sampled LAT+1 edges after grant.
    chk($sformatf("t%0d_ack_latency", idx), ack_at - g, t.lat);
    chk($sformatf("t%0d_ce_target", idx), target_ok, 1);
    chk($sformatf("t%0d_bus_hold", idx), hold_ok, 1);
    if (t.who == 1) begin
      chk($sformatf("t%0d_wait_low", idx), wait_ok, 1);
      chk($sformatf("t%0d_wait_high_at_ack", idx), cpu_wait_n, 1);
    end
    set_req(t.who, 1'b0);
    if (t.rnw && t.who == 1) last_cpu_rd = t.exp_rd;
    if (t.rnw && t.who == 2) last_sv_rd = t.exp_rd;
    @(negedge clk21m);
    chk($sformatf("t%0d_ack_one_cycle", idx), {dl_ack, cpu_ack, sv_ack}, 3'b000);
    chk($sformatf("t%0d_rnw_idle", idx), ram_rnw, 1);
    chk($sformatf("t%0d_cpu_rdata", idx), cpu_rdata, last_cpu_rd);
    chk($sformatf("t%0d_sv_rdata", idx), sv_rdata, last_sv_rd);
  endtask

  initial begin
    int k, ce_rises, acks, both_ce;
    bit prev_ce;
    int order[3];
    int at[3];
    logic [26:0] gaddr[3];
    int seq[10];
    int exp_seq[10];
    txn_t post;

    tbl[0] = '{1, 1'b0, 27'h0001234, 1'b1, 8'h00, 8'hA5, 2, 8'hA5};
    tbl[1] = '{2, 1'b1, 27'h0100000, 1'b0, 8'h3C, 8'h00, 4, 8'h00};
    tbl[2] = '{1, 1'b1, 27'h7FFFFFF, 1'b0, 8'hFF, 8'h00, 4, 8'h00};
    tbl[3] = '{2, 1'b0, 27'h0000000, 1'b1, 8'h00, 8'h5A, 2, 8'h5A};
    tbl[4] = '{0, 1'b1, 27'h0012345, 1'b0, 8'h81, 8'h00, 4, 8'h00};
    tbl[5] = '{1, 1'b1, 27'h4000001, 1'b1, 8'h00, 8'h00, 4, 8'h00};
    tbl[6] = '{2, 1'b1, 27'h2AAAAAA, 1'b1, 8'h00, 8'hC3, 4, 8'hC3};

    reset = 1'b1;
    dl_req = 0; cpu_req = 0; sv_req = 0;
    dl_addr = '0; cpu_addr = '0; sv_addr = '0;
    dl_wdata = '0; cpu_wdata = '0; sv_wdata = '0;
    cpu_sdram = 0; cpu_rnw = 1; sv_sdram = 0; sv_rnw = 1; ram_dout = '0;
    repeat (3) @(negedge clk21m);
    chk("rst_acks", {dl_ack, cpu_ack, sv_ack}, 3'b000);
    chk("rst_wait_n", cpu_wait_n, 1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_ram_rnw", ram_rnw, 1);
    chk("rst_ce", {sdram_ce, bram_ce}, 2'b00);
    chk("rst_rdata", {cpu_rdata, sv_rdata}, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(i, tbl[i]);

    // All three requesters raised together: expect dl, cpu, sv in turn.
    @(negedge clk21m);
    dl_addr = 27'h0000100; dl_wdata = 8'h11;
    cpu_addr = 27'h0000200; cpu_wdata = 8'h22; cpu_rnw = 0; cpu_sdram = 0;
    sv_addr = 27'h0000300; sv_wdata = 8'h33; sv_rnw = 0; sv_sdram = 1;
    dl_req = 1; cpu_req = 1; sv_req = 1;
    k = 0; both_ce = 0; prev_ce = 0;
    for (int n = 0; n < 60 && k < 3; n++) begin
      @(negedge clk21m);
      if (sdram_ce && bram_ce) both_ce++;
      if ((sdram_ce || bram_ce) && !prev_ce) gaddr[k] = ram_addr;
      prev_ce = sdram_ce || bram_ce;
      if (dl_ack) begin order[k] = 0; at[k] = n; k++; dl_req = 0; end
      else if (cpu_ack) begin order[k] = 1; at[k] = n; k++; cpu_req = 0; end
      else if (sv_ack) begin order[k] = 2; at[k] = n; k++; sv_req = 0; end
    end
    dl_req = 0; cpu_req = 0; sv_req = 0;
    chk("simul_ack_count", k, 3);
    chk("simul_order", {order[0][1:0], order[1][1:0], order[2][1:0]}, 6'b00_01_10);
    chk("simul_gap_dl_cpu", at[1] - at[0], 4);
    chk("simul_gap_cpu_sv", at[2] - at[1], 6);
    chk("simul_grant_addr", {gaddr[0], gaddr[1], gaddr[2]}, {27'h0000100, 27'h0000200, 27'h0000300});
    chk("simul_no_ce_overlap", both_ce, 0);

    // Starvation: cpu and sv held high; sv must get in after STARVE_MAX cpu grants.
    @(negedge clk21m);
    cpu_rnw = 1; cpu_sdram = 0; sv_rnw = 1; sv_sdram = 0; ram_dout = 8'h42;
    for (int i = 0; i < 10; i++) exp_seq[i] = (i == 8) ? 2 : 1;
    cpu_req = 1; sv_req = 1;
    k = 0;
    for (int n = 0; n < 300 && k < 10; n++) begin
      @(negedge clk21m);
      if (cpu_ack) begin seq[k] = 1; k++; end
      else if (sv_ack) begin seq[k] = 2; k++; end
      else if (dl_ack) begin seq[k] = 0; k++; end
    end
    cpu_req = 0; sv_req = 0;
    last_cpu_rd = 8'h42; last_sv_rd = 8'h42;
    chk("starve_ack_count", k, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("starve_seq%0d", i), seq[i], exp_seq[i]);
    @(negedge clk21m);

    // Reset in the second cycle of an SDRAM access aborts it.
    @(negedge clk21m);
    cpu_addr = 27'h0055555; cpu_wdata = 8'h99; cpu_rnw = 0; cpu_sdram = 1;
    cpu_req = 1;
    k = -1;
    for (int n = 0; n < 10 && k < 0; n++) begin
      @(negedge clk21m);
      if (sdram_ce) k = n;
    end
    chk("rstmid_ce_seen", k >= 0, 1);
    @(negedge clk21m);
    reset = 1; cpu_req = 0;
    #1;
    chk("rstmid_ce_drop", {sdram_ce, bram_ce}, 2'b00);
    chk("rstmid_rnw", ram_rnw, 1);
    chk("rstmid_addr", ram_addr, 0);
    chk("rstmid_din", ram_din, 0);
    chk("rstmid_rdata", {cpu_rdata, sv_rdata}, 16'h0000);
    chk("rstmid_wait_n", cpu_wait_n, 1);
    last_cpu_rd = 8'h00; last_sv_rd = 8'h00;
    acks = 0; ce_rises = 0;
    repeat (2) begin
      @(negedge clk21m);
      if (dl_ack || cpu_ack || sv_ack) acks++;
    end
    reset = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk21m);
      if (dl_ack || cpu_ack || sv_ack) acks++;
      if (sdram_ce || bram_ce) ce_rises++;
    end
    chk("rstmid_no_ack", acks, 0);
    chk("rstmid_no_ce", ce_rises, 0);
    post = '{1, 1'b0, 27'h0003210, 1'b1, 8'h00, 8'h6E, 2, 8'h6E};
    run_txn(7, post);

    // cpu_req dropped mid-access: still exactly one ack and one grant.
    @(negedge clk21m);
    cpu_addr = 27'h0ABCDEF; cpu_rnw = 1; cpu_sdram = 1; ram_dout = 8'h77;
    cpu_req = 1;
    k = -1;
    for (int n = 0; n < 10 && k < 0; n++) begin
      @(negedge clk21m);
      if (sdram_ce) k = n;
    end
    chk("drop_ce_seen", k >= 0, 1);
    @(negedge clk21m);
    cpu_req = 0;
    acks = 0; ce_rises = 0; prev_ce = sdram_ce || bram_ce;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk21m);
      if (cpu_ack) acks++;
      if ((sdram_ce || bram_ce) && !prev_ce) ce_rises++;
      prev_ce = sdram_ce || bram_ce;
    end
    chk("drop_ack_once", acks, 1);
    chk("drop_no_regrant", ce_rises, 0);
    chk("drop_rdata", cpu_rdata, 8'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
